// File: rtl/ser_pkg.sv
// Shared types and sizing helpers for the PISO bit serializer.
// SER_PARITY_EN: when defined, frames carry one trailing even-parity bit.
package ser_pkg;

   // Serializer control states
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StGapw  = 2'd2
   } ser_state_e;

`ifdef SER_PARITY_EN
   localparam int unsigned ParityBits = 1;
`else
   localparam int unsigned ParityBits = 0;
`endif

   // Serial frame length in bits for a given data width
   function automatic int unsigned frame_len(input int unsigned width);
      return width + ParityBits;
   endfunction

   // Counter width able to hold every index up to width+1 without wrap
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 2);
   endfunction

endpackage

// File: rtl/ser_bit_cnt.sv
// Clearable up-counter that saturates at MAX-1 and flags the terminal count.
// Used for both the frame bit count and the inter-word gap count.
// SER_PARITY_EN has no effect in this file.
module ser_bit_cnt #(
   parameter int unsigned MAX   = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   logic [CNT_W-1:0] r_cnt;

   // Count up while enabled, hold at terminal count, clear on request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_tc) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tc = (r_cnt == CNT_W'(MAX - 1));

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: accepts a word on valid/ready, shifts it out
// one bit per clock with a bit-valid qualifier and a last-bit done pulse.
// SER_PARITY_EN: when defined, an even-parity bit follows the data bits.
module piso_bit_serializer
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned GAP       = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned FRAME = frame_len(WIDTH);
   localparam int unsigned CNT_W = cnt_width(WIDTH);

   ser_state_e       r_state;
   ser_state_e       w_state_next;
   logic [WIDTH-1:0] r_shreg;
   logic             w_accept;
   logic             w_bit_tc;
   logic             w_gap_tc;
   logic             w_last;
   logic             w_data_bit;
   logic             w_bit;

   assign w_last = (r_state == StShift) && w_bit_tc;

   // Ready in IDLE, and on the last frame bit when words may run back-to-back
   assign in_ready = !rst && ((r_state == StIdle) || ((GAP == 0) && w_last));
   assign w_accept = in_valid && in_ready;

   ser_bit_cnt #(
      .MAX   (FRAME),
      .CNT_W (CNT_W)
   ) u_bit_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_accept || (r_state != StShift)),
      .i_en  (r_state == StShift),
      .o_tc  (w_bit_tc)
   );

   if (GAP > 0) begin : g_gap
      ser_bit_cnt #(
         .MAX   (GAP),
         .CNT_W (cnt_width(GAP))
      ) u_gap_cnt (
         .clk   (clk),
         .rst   (rst),
         .i_clr (r_state != StGapw),
         .i_en  (r_state == StGapw),
         .o_tc  (w_gap_tc)
      );
   end else begin : g_no_gap
      assign w_gap_tc = 1'b1;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state selection
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) w_state_next = StShift;
         end
         StShift: begin
            if (w_bit_tc) begin
               if (GAP > 0)       w_state_next = StGapw;
               else if (w_accept) w_state_next = StShift;
               else               w_state_next = StIdle;
            end
         end
         StGapw: begin
            if (w_gap_tc) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Shift register: load on accept, move one bit toward the output per SHIFT cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg <= '0;
      end else if (w_accept) begin
         r_shreg <= in_data;
      end else if (r_state == StShift) begin
         if (MSB_FIRST) r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
         else           r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      end
   end

   assign w_data_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

`ifdef SER_PARITY_EN
   logic r_par;

   // Capture even parity of the accepted word; sent on the final frame bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_par <= 1'b0;
      end else if (w_accept) begin
         r_par <= ^in_data;
      end
   end

   assign w_bit = w_bit_tc ? r_par : w_data_bit;
`else
   assign w_bit = w_data_bit;
`endif

   // Outputs decode straight from registered state so reset clears them at once
   always_comb begin
      ser_valid = (r_state == StShift);
      ser_out   = (r_state == StShift) ? w_bit : 1'b0;
      busy      = (r_state != StIdle);
      done      = w_last;
   end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: three differently configured instances driven
// in lockstep, checked every cycle against a queue-based frame model.
// SER_PARITY_EN: when defined, the model appends an even-parity bit per frame.
module tb_piso_bit_serializer;

   localparam int NI = 3;

   // Instance configurations: {WIDTH, MSB_FIRST, GAP}
   function automatic int unsigned cfg_w(input int k);
      return (k == 2) ? 8 : 4;
   endfunction
   function automatic int unsigned cfg_msb(input int k);
      return (k == 1) ? 0 : 1;
   endfunction
   function automatic int unsigned cfg_gap(input int k);
      case (k)
         0:       return 0;
         1:       return 2;
         default: return 1;
      endcase
   endfunction

   typedef struct packed {
      logic b;
      logic v;
      logic d;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    tb_data [NI];
   logic [NI-1:0] tb_valid;
   logic [NI-1:0] o_rdy, o_ser, o_sv, o_busy, o_done;

   exp_t exp_q [NI][$];
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned W = cfg_w(g);
      piso_bit_serializer #(
         .WIDTH     (W),
         .MSB_FIRST (cfg_msb(g) != 0),
         .GAP       (cfg_gap(g))
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_data   (tb_data[g][W-1:0]),
         .in_valid  (tb_valid[g]),
         .in_ready  (o_rdy[g]),
         .ser_out   (o_ser[g]),
         .ser_valid (o_sv[g]),
         .busy      (o_busy[g]),
         .done      (o_done[g])
      );
   end

   task automatic chk(input string tag, input logic got, input logic want);
      n_cmp++;
      if (got !== want) begin
         n_mis++;
         $display("FAIL %s got=%b want=%b @%0t", tag, got, want, $time);
      end
   endtask

   // Model: idle when nothing is pending; with no gap, also ready on a last bit
   function automatic logic m_ready(input int k);
      if (rst) return 1'b0;
      if (exp_q[k].size() == 0) return 1'b1;
      return (cfg_gap(k) == 0) && (exp_q[k].size() == 1) && exp_q[k][0].d;
   endfunction

   // Model: queue the per-cycle outputs for one accepted word
   task automatic push_frame(input int k, input logic [7:0] word);
      int unsigned w;
      int unsigned fl;
      logic [7:0]  m;
      logic [8:0]  bits;
      w  = cfg_w(k);
      m  = word;
      for (int i = int'(w); i < 8; i++) m[i] = 1'b0;
      bits = '0;
      for (int i = 0; i < int'(w); i++)
         bits[i] = (cfg_msb(k) != 0) ? m[int'(w) - 1 - i] : m[i];
      fl = w;
`ifdef SER_PARITY_EN
      bits[w] = ^m;
      fl = w + 1;
`endif
      for (int i = 0; i < int'(fl); i++)
         exp_q[k].push_back('{b: bits[i], v: 1'b1, d: (i == int'(fl) - 1)});
      for (int i = 0; i < int'(cfg_gap(k)); i++)
         exp_q[k].push_back('{b: 1'b0, v: 1'b0, d: 1'b0});
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (rst) begin
            exp_q[k].delete();
         end else begin
            logic acc;
            acc = tb_valid[k] && m_ready(k);
            if (exp_q[k].size() > 0) void'(exp_q[k].pop_front());
            if (acc) push_frame(k, tb_data[k]);
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         exp_t e;
         e = '0;
         if (!rst && exp_q[k].size() > 0) e = exp_q[k][0];
         chk($sformatf("i%0d ser_valid", k), o_sv[k], e.v);
         chk($sformatf("i%0d ser_out", k), o_ser[k], e.b);
         chk($sformatf("i%0d done", k), o_done[k], e.d);
         chk($sformatf("i%0d busy", k), o_busy[k], !rst && (exp_q[k].size() != 0));
         chk($sformatf("i%0d in_ready", k), o_rdy[k], m_ready(k));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tb_valid = '0;
      for (int k = 0; k < NI; k++) tb_data[k] = 8'h00;
      rst = 1'b0;
      #1 rst = 1'b1;
      #20 rst = 1'b0;

      // Single words: 1010 on the 4-bit instances, B4 on the 8-bit one
      step();
      tb_data[0] = 8'h0A; tb_data[1] = 8'h0A; tb_data[2] = 8'hB4;
      tb_valid   = '1;
      step();
      tb_valid = '0;
      repeat (14) step();

      // Odd-parity word on the 8-bit instance
      tb_data[2] = 8'h07;
      tb_valid   = 3'b100;
      step();
      tb_valid = '0;
      repeat (12) step();

      // Valid held high: back-to-back on GAP=0, gap spacing on the others
      tb_data[0] = 8'h0A; tb_data[1] = 8'h0A; tb_data[2] = 8'hA5;
      tb_valid   = '1;
      step();
      tb_data[0] = 8'h05; tb_data[1] = 8'h05; tb_data[2] = 8'h3C;
      repeat (8) step();
      tb_valid = '0;
      repeat (20) step();

      // Reset in the middle of a frame, after its second bit
      tb_data[0] = 8'h0C; tb_data[1] = 8'h0C; tb_data[2] = 8'hCC;
      tb_valid   = '1;
      step();
      tb_valid = '0;
      step();
      step();
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("i%0d async ser_valid", k), o_sv[k], 1'b0);
         chk($sformatf("i%0d async ser_out", k), o_ser[k], 1'b0);
         chk($sformatf("i%0d async busy", k), o_busy[k], 1'b0);
         chk($sformatf("i%0d async done", k), o_done[k], 1'b0);
         chk($sformatf("i%0d async in_ready", k), o_rdy[k], 1'b0);
      end
      step();
      rst = 1'b0;
      step();
      tb_data[0] = 8'h09; tb_data[1] = 8'h06; tb_data[2] = 8'h5A;
      tb_valid   = '1;
      step();
      tb_valid = '0;
      repeat (14) step();

      // Random traffic with bubbles and data changing while not accepted
      repeat (400) begin
         for (int k = 0; k < NI; k++) begin
            tb_valid[k] = ($urandom_range(0, 3) != 0);
            tb_data[k]  = 8'($urandom);
         end
         step();
      end
      tb_valid = '0;
      repeat (30) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock, with a bit-valid qualifier.
- Produces the serial bit stream consumed by the team's serial sequence-detector FSMs (e.g. the 1010 Mealy detector input x).
- Supports back-to-back words and an optional idle gap between words.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- MSB_FIRST, 1, 1 = shift MSB first; 0 = LSB first.
- GAP, 0, idle cycles inserted after each word (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  parallel word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit; feeds the detector's x.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse coincident with the last frame bit.

Behaviour:
- Clocking and reset: one clock domain. rst is asynchronous and active-high. While rst is high, all registers are cleared: state=IDLE, shift register=0, bit counter=0, gap counter=0, ser_out=0, ser_valid=0, done=0, busy=0. in_ready is forced to 0 while rst is high.
- States: IDLE, SHIFT, GAPW.
- IDLE:
  - in_ready=1, ser_valid=0, ser_out=0.
  - On in_valid&&in_ready: latch in_data into shreg, bit counter=0, go to SHIFT.
  - Latency: first bit appears on ser_out in the cycle after the accept edge.
- SHIFT:
  - ser_valid=1.
  - ser_out=shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - Each clock, shift shreg by one toward the output and increment the counter.
  - The last bit is the cycle with counter==FRAME-1, where FRAME=WIDTH (WIDTH+1 with parity). In that cycle done=1.
  - After the last bit:
    - GAP>0: go to GAPW.
    - GAP==0: in_ready=1 combinationally during the last-bit cycle. If in_valid is high, reload and stay in SHIFT, so the next word's first bit follows with zero bubble. Otherwise go to IDLE.
  - in_ready=0 in every other SHIFT cycle; in_data is ignored there.
- GAPW:
  - ser_valid=0, ser_out=0, in_ready=0.
  - Lasts exactly GAP cycles, then goes to IDLE.
- Word accepted is held in shreg; later changes to in_data have no effect on the frame in flight.
- Reset mid-frame: the frame is discarded, outputs go to 0 immediately (asynchronously), and no partial done pulse is issued.
- Counter width: $clog2(WIDTH+2) bits. No wrap beyond FRAME-1.
- busy=1 in SHIFT and GAPW.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined: one even-parity bit (XOR of the accepted word) is appended after the data bits.
  - The frame is WIDTH+1 bits; the parity bit has ser_valid=1.
  - done pulses on the parity bit.
  - The back-to-back ready window moves to the parity cycle.
- Undefined: frame is WIDTH bits and no parity logic exists.

Decomposition:
- Package ser_pkg:
  - state enum (IDLE, SHIFT, GAPW);
  - localparam FRAME computation;
  - counter-width helper constant.
- Sub-module ser_bit_cnt: loadable up-counter with terminal-count flag, parameterised by FRAME. It is used for both the bit count and the gap count.

Test Plan:
1. WIDTH=4, MSB_FIRST=1: rst high 20 ns then low; accept 4'b1010 -> ser_out 1,0,1,0 on the 4 cycles after accept; ser_valid=1 for 4 cycles; done on the 4th; then IDLE, in_ready=1.
2. MSB_FIRST=0, word 4'b1010 -> ser_out 0,1,0,1.
3. Back-to-back, GAP=0: in_valid held high with 4'b1010 then 4'b0101 -> 8 consecutive ser_valid cycles; ser_out 1,0,1,0,0,1,0,1; two done pulses 4 cycles apart.
4. GAP=2: two words -> exactly 2 cycles with ser_valid=0 between the frames; in_ready=0 during the gap.
5. Reset mid-frame: assert rst after the 2nd bit of 4'b1100 -> ser_valid, ser_out and busy go to 0 at once; no done pulse; a new word after release starts cleanly.
6. SER_PARITY_EN, WIDTH=8, word 8'hB4 (four 1s) -> 9 bits with parity bit 0. Word 8'h07 -> parity bit 1. done is on the 9th bit.
